irq_priority_encoder: RTL
=========================

Name: irq_priority_encoder

Overview:
- Sequential 4-to-2 priority encoder with an enable gate; the encode-side counterpart of the 2-to-4 gated decoder.
- Captures rising edges on four request lines into sticky pending bits.
- Presents the highest-priority pending index as a 2-bit code with a valid/ack handshake.
- Sits between peripheral interrupt/event lines and the SoC controller, which consumes the code and acknowledges it.

Parameters:
N_REQ, 4, number of request lines (fixed at 4 for this revision)
CODE_W, 2, code width, equal to log2(N_REQ)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
enable  input  1  gate; 0 suppresses presentation of codes
req  input  4  level request lines, synchronous to clk; req[3] is highest priority
ack  input  1  consumer acknowledge; valid only while valid=1
valid  output  1  code is being presented
code  output  2  index of the granted request (3..0)
pending  output  4  current sticky pending bits
overflow  output  1  one-cycle pulse: a rising edge hit an already-pending bit

Behaviour:
- Reset (rst_n=0, asynchronous):
  - valid=0, code=2'b00, pending=4'b0000, overflow=0.
  - req_q=4'b0000 and FSM=IDLE.
  - Any req held high at reset release counts as a rising edge on the first clock edge.
- Edge capture, every clock edge regardless of enable:
  - rise = req & ~req_q; then req_q <= req.
  - pending <= (pending & ~clr) | rise.
  - clr is one-hot at code when an ack is accepted, else 0.
  - Set wins over clear on the same bit in the same cycle.
- Overflow:
  - overflow <= |(rise & pending & ~clr).
  - Registered, one cycle wide; no counting.
- FSM, two states:
  - IDLE: valid=0, code=00. If enable=1 and |pending, latch code = index of the highest set pending bit and go to PRESENT.
  - PRESENT: valid=1, code held stable. If enable=0, go to IDLE with pending unchanged. Else if ack=1, accept: clear pending[code] and go to IDLE. Else stay.
- Latency:
  - req rises before edge E0, so pending is set at E0.
  - valid=1 and code appear after E1: 2 cycles from req high to valid.
- Throughput:
  - After an accepted ack, valid drops for at least one cycle.
  - The next grant appears after the following edge, giving a minimum of 2 cycles per grant.
- No preemption: a higher-priority edge arriving while PRESENT waits for the current grant to complete.
- ack while valid=0 is ignored, with no side effects.
- enable=0:
  - Forces valid=0 and code=00 on the next edge.
  - Captures continue, so pending keeps accumulating.
  - Re-enabling with pending≠0 gives valid after one edge.
- Code encoding matches the decoder: code=2'b11 selects req[3], down to 2'b00 for req[0].
- With pending=4'b0000 and enable=1, the FSM stays in IDLE; code is never presented for an empty set.

Decomposition:
- Shared package/include holds:
  - N_REQ and CODE_W.
  - State encodings ST_IDLE=1'b0 and ST_PRESENT=1'b1.
  - Reset value constants for code and pending.
- Sub-module prio_enc4: purely combinational 4-to-2 priority encoder (in[3:0] -> idx[1:0], any).
  - Highest index wins; idx=00 when any=0.
  - Instantiated once, on pending.

Test Plan:
- Reset, then pulse req=4'b0100 for one cycle, enable=1 -> valid=1, code=2'b10 exactly 2 cycles later; ack held 1 -> pending=0000, valid=0 next cycle.
- Raise req=4'b1010 in the same cycle, ack each grant -> first grant code=11, then after an idle cycle code=01; pending 1010 -> 0010 -> 0000.
- While PRESENT with code=01, raise req[3] -> code stays 01 until ack; next grant code=11 (no preemption).
- enable=0 and req[0] rises -> valid stays 0, pending=0001; set enable=1 -> valid=1, code=00 one cycle later.
- Same-cycle clear/set and overflow:
  - req[2] falls and rises again while pending[2]=1 and not acked -> overflow pulses for exactly one cycle.
  - A re-rise of req[2] in the same cycle as the ack of code=10 -> pending[2] remains 1, and code=10 is presented again.
- Assert rst_n=0 asynchronously mid-PRESENT -> valid, code, pending and overflow go to 0 immediately without a clock edge; after release, a held req[1] yields code=01 within 2 cycles.

Source files
------------

// File: rtl/irq_priority_encoder_pkg.sv
// irq_priority_encoder_pkg: shared sizes, state encodings and reset values
package irq_priority_encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    localparam logic [CODE_W-1:0] CODE_RST = '0;
    localparam logic [N_REQ-1:0]  PEND_RST = '0;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
        logic [N_REQ-1:0] one;
        one = 1;
        return one << c;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// prio_enc4: combinational 4-to-2 priority encoder, highest index wins
module prio_enc4
    import irq_priority_encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  in,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    assign any = |in;
    assign idx = in[3] ? 2'd3 : in[2] ? 2'd2 : in[1] ? 2'd1 : 2'd0;

endmodule

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: sticky rising-edge capture with gated valid/ack presentation of the top pending index
module irq_priority_encoder
    import irq_priority_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic [N_REQ-1:0]  pending,
    output logic              overflow
);

    logic                req_q;
    logic [N_REQ-1:0]    req_d;
    logic [N_REQ-1:0]    rise;
    logic [N_REQ-1:0]    clr;
    logic [CODE_W-1:0]   idx;
    logic                any;
    logic                state;

    assign req_q = 1'b0;
    assign rise  = req & ~req_d;
    // an ack only counts while the code is actually being presented and still enabled
    assign clr   = (state == ST_PRESENT && enable && ack) ? onehot(code) : '0;
    assign valid = state == ST_PRESENT;

    prio_enc4 u_enc (
        .in  (pending),
        .idx (idx),
        .any (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d    <= '0;
            pending  <= PEND_RST;
            overflow <= 1'b0;
            state    <= ST_IDLE;
            code     <= CODE_RST;
        end else begin
            req_d    <= req;
            pending  <= (pending & ~clr) | rise;
            overflow <= |(rise & pending & ~clr);
            if (state == ST_IDLE) begin
                if (enable && any) begin
                    state <= ST_PRESENT;
                    code  <= idx;
                end
            end else if (!enable || ack) begin
                state <= ST_IDLE;
                code  <= CODE_RST;
            end
        end
    end

endmodule
